// File: rtl/wb_mem_arbiter_pkg.sv
// wb_mem_arbiter_pkg: state encoding and default constants shared by the memory arbiter
package wb_mem_arbiter_pkg;
   typedef enum logic [1:0] {IDLE = 2'b00, GNT_I = 2'b01, GNT_D = 2'b10} arb_state_t;
   localparam int DEF_AW          = 32;
   localparam int DEF_DW          = 32;
   localparam int SEL_W           = 4;
   localparam int DEF_TIMEOUT     = 1023;
   localparam int DEF_MAX_DSTREAK = 4;
endpackage

// File: rtl/wb_timeout_ctr.sv
// wb_timeout_ctr: loadable down-counter; expire fires on an enabled cycle once the count has run out
module wb_timeout_ctr #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         expire
);
   logic [W-1:0] cnt;
   assign expire = en && cnt == '0;
   // reload while idle, count down on each enabled cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (en && cnt != '0) cnt <= cnt - 1'b1;
   end
endmodule

// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: shares one Wishbone classic memory slave between the fetch and data masters
module wb_mem_arbiter
   import wb_mem_arbiter_pkg::*;
#(
   parameter int AW          = DEF_AW,
   parameter int DW          = DEF_DW,
   parameter int TIMEOUT     = DEF_TIMEOUT,
   parameter int MAX_DSTREAK = DEF_MAX_DSTREAK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    iaddr_i,
   input  logic [DW-1:0]    idat_i,
   input  logic [SEL_W-1:0] isel_i,
   input  logic             icyc_i,
   input  logic             istb_i,
   input  logic             iwe_i,
   output logic [DW-1:0]    idat_o,
   output logic             iack_o,
   output logic             ierr_o,
   input  logic [AW-1:0]    daddr_i,
   input  logic [DW-1:0]    ddat_i,
   input  logic [SEL_W-1:0] dsel_i,
   input  logic             dcyc_i,
   input  logic             dstb_i,
   input  logic             dwe_i,
   output logic [DW-1:0]    ddat_o,
   output logic             dack_o,
   output logic             derr_o,
   output logic [AW-1:0]    maddr_o,
   output logic [DW-1:0]    mdat_o,
   output logic [SEL_W-1:0] msel_o,
   output logic             mcyc_o,
   output logic             mstb_o,
   output logic             mwe_o,
   input  logic [DW-1:0]    mdat_i,
   input  logic             mack_i,
   input  logic             merr_i,
   output logic             timeout_o
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int SW = $clog2(MAX_DSTREAK + 1);
   arb_state_t    state;
   logic [SW-1:0] dstreak;
   logic          ireq, dreq, gi, gd, g, xcyc, rsp, done, expire, sat, pick_i, ack, err;
   assign ireq   = icyc_i & istb_i;
   assign dreq   = dcyc_i & dstb_i;
   assign gi     = state == GNT_I;
   assign gd     = state == GNT_D;
   assign g      = gi | gd;
   assign sat    = dstreak == SW'(MAX_DSTREAK);
   assign pick_i = ireq & (~dreq | sat);
   assign rsp    = mack_i | merr_i;
   assign xcyc   = gi ? icyc_i : gd & dcyc_i;
   assign done   = g & (rsp | ~xcyc | expire);
   assign err    = g & (merr_i | expire);
   assign ack    = g & mack_i & ~merr_i;
   assign mcyc_o    = xcyc;
   assign mstb_o    = gi ? istb_i : gd & dstb_i;
   assign mwe_o     = gi ? iwe_i : gd & dwe_i;
   assign maddr_o   = gi ? iaddr_i : gd ? daddr_i : '0;
   assign mdat_o    = gi ? idat_i : gd ? ddat_i : '0;
   assign msel_o    = gi ? isel_i : gd ? dsel_i : '0;
   assign idat_o    = gi ? mdat_i : '0;
   assign ddat_o    = gd ? mdat_i : '0;
   assign iack_o    = gi & ack;
   assign ierr_o    = gi & err;
   assign dack_o    = gd & ack;
   assign derr_o    = gd & err;
   assign timeout_o = expire;
   wb_timeout_ctr #(.W(TW)) u_tmo (
      .clk      (clk),
      .rst      (rst),
      .load     (state == IDLE),
      .load_val (TW'(TIMEOUT - 1)),
      .en       (g & ~rsp),
      .expire   (expire)
   );
   // grant FSM plus the count of data grants completed while fetch kept waiting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         dstreak <= '0;
      end else begin
         state   <= g ? (done ? IDLE : state) : pick_i ? GNT_I : dreq ? GNT_D : IDLE;
         dstreak <= (!ireq || (!g && pick_i)) ? '0 : (gd && done && !sat) ? dstreak + 1'b1 : dstreak;
      end
   end
endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb_wb_mem_arbiter: scoreboarded random and directed checks of the fetch/data memory arbiter
module tb_wb_mem_arbiter;
   localparam int TMO = 16, MDS = 4;
   localparam int K_ACK = 0, K_ERR = 1, K_BOTH = 2, K_TO = 3;
   typedef struct {
      logic [31:0] addr, wdat, rdat;
      logic [3:0]  sel;
      logic        we;
      int          kind, dly;
   } txn_t;
   logic        clk = 0, rst = 1;
   logic [31:0] iaddr_i = 0, idat_i = 0, daddr_i = 0, ddat_i = 0, mdat_i = 0;
   logic [3:0]  isel_i = 0, dsel_i = 0;
   logic        icyc_i = 0, istb_i = 0, iwe_i = 0, dcyc_i = 0, dstb_i = 0, dwe_i = 0, mack_i = 0, merr_i = 0;
   logic [31:0] idat_o, ddat_o, maddr_o, mdat_o;
   logic [3:0]  msel_o;
   logic        iack_o, ierr_o, dack_o, derr_o, mcyc_o, mstb_o, mwe_o, timeout_o;
   txn_t        iq[$], dq[$];
   bit          order[$];
   int          errors = 0, checks = 0, gcnt = 0;
   bit          spur = 0, to_flag = 0;

   always #5 clk = ~clk;

   wb_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TMO), .MAX_DSTREAK(MDS)) dut (
      .clk(clk), .rst(rst),
      .iaddr_i(iaddr_i), .idat_i(idat_i), .isel_i(isel_i), .icyc_i(icyc_i), .istb_i(istb_i), .iwe_i(iwe_i),
      .idat_o(idat_o), .iack_o(iack_o), .ierr_o(ierr_o),
      .daddr_i(daddr_i), .ddat_i(ddat_i), .dsel_i(dsel_i), .dcyc_i(dcyc_i), .dstb_i(dstb_i), .dwe_i(dwe_i),
      .ddat_o(ddat_o), .dack_o(dack_o), .derr_o(derr_o),
      .maddr_o(maddr_o), .mdat_o(mdat_o), .msel_o(msel_o), .mcyc_o(mcyc_o), .mstb_o(mstb_o), .mwe_o(mwe_o),
      .mdat_i(mdat_i), .mack_i(mack_i), .merr_i(merr_i), .timeout_o(timeout_o)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic txn_t mk(input logic [31:0] a, input logic we, input logic [3:0] sel,
                               input logic [31:0] wd, input logic [31:0] rd, input int kind, input int dly);
      txn_t t;
      t.addr = a; t.we = we; t.sel = sel; t.wdat = wd; t.rdat = rd; t.kind = kind; t.dly = dly;
      return t;
   endfunction

   // fetch addresses live below 2 GiB and data addresses above, so the slave can tell them apart
   function automatic txn_t rnd(input bit m, input int kind, input int dly);
      return mk({m, 31'($urandom())}, 1'($urandom()), 4'($urandom()), $urandom(), $urandom(), kind, dly);
   endfunction

   function automatic int rnd_kind();
      int r;
      r = $urandom_range(0, 19);
      return r < 12 ? K_ACK : r < 15 ? K_ERR : r < 18 ? K_BOTH : K_TO;
   endfunction

   task automatic do_txn(input bit m, input txn_t t, output int lat);
      @(posedge clk); #1;
      if (m) begin
         dq.push_back(t);
         daddr_i = t.addr; ddat_i = t.wdat; dsel_i = t.sel; dwe_i = t.we; dcyc_i = 1; dstb_i = 1;
      end else begin
         iq.push_back(t);
         iaddr_i = t.addr; idat_i = t.wdat; isel_i = t.sel; iwe_i = t.we; icyc_i = 1; istb_i = 1;
      end
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!(m ? (dack_o || derr_o) : (iack_o || ierr_o)) && lat < 200);
      if (lat >= 200) begin
         checks++;
         errors++;
         $display("FAIL %s_no_response: no ack/err after %0d cycles, expected one", m ? "d" : "i", lat);
         if (m) dq.delete(); else iq.delete();
      end
   endtask

   task automatic idle(input bit m, input int n);
      @(posedge clk); #1;
      if (m) begin dcyc_i = 0; dstb_i = 0; end
      else begin icyc_i = 0; istb_i = 0; end
      repeat (n) @(posedge clk);
   endtask

   task automatic check_rsp(input string m, input txn_t t, input logic ack, input logic err,
                            input logic [31:0] dat, input logic [33:0] other);
      chk({m, "_ack"}, ack, t.kind == K_ACK);
      chk({m, "_err"}, err, t.kind != K_ACK);
      chk({m, "_timeout"}, timeout_o, t.kind == K_TO);
      chk({m, "_cyc_stb"}, {mcyc_o, mstb_o}, 2'b11);
      chk({m, "_addr"}, maddr_o, t.addr);
      chk({m, "_we"}, mwe_o, t.we);
      chk({m, "_sel"}, msel_o, t.sel);
      if (t.we) chk({m, "_wdat"}, mdat_o, t.wdat);
      if (t.kind == K_ACK) chk({m, "_rdat"}, dat, t.rdat);
      chk({m, "_other_quiet"}, other, 0);
      if (t.kind == K_TO) begin
         chk({m, "_timeout_cycle"}, gcnt, TMO);
         to_flag = 1;
      end
   endtask

   // slave: answers the transfer on the bus after its scripted number of granted cycles
   initial begin
      txn_t t;
      bit   hit;
      forever begin
         @(posedge clk); #2;
         mack_i = spur; merr_i = 0; mdat_i = $urandom();
         if (rst || !(mcyc_o && mstb_o)) gcnt = 0;
         else begin
            gcnt++;
            hit = 0;
            if (dq.size() > 0 && dq[0].addr == maddr_o) begin t = dq[0]; hit = 1; end
            else if (iq.size() > 0 && iq[0].addr == maddr_o) begin t = iq[0]; hit = 1; end
            if (hit && t.kind != K_TO && gcnt == t.dly) begin
               mack_i = t.kind != K_ERR;
               merr_i = t.kind != K_ACK;
               mdat_i = t.rdat;
            end
         end
      end
   end

   // monitor: every ack/err the masters see is matched against the scoreboard
   initial begin
      txn_t t;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (to_flag) begin
               chk("mcyc_after_timeout", mcyc_o, 0);
               to_flag = 0;
            end
            if (timeout_o && !(ierr_o || derr_o)) chk("timeout_without_err", timeout_o, 0);
            if (iack_o || ierr_o) begin
               if (iq.size() == 0) chk("i_unexpected", {iack_o, ierr_o}, 0);
               else begin
                  t = iq.pop_front();
                  order.push_back(0);
                  check_rsp("i", t, iack_o, ierr_o, idat_o, {dack_o, derr_o, ddat_o});
               end
            end
            if (dack_o || derr_o) begin
               if (dq.size() == 0) chk("d_unexpected", {dack_o, derr_o}, 0);
               else begin
                  t = dq.pop_front();
                  order.push_back(1);
                  check_rsp("d", t, dack_o, derr_o, ddat_o, {iack_o, ierr_o, idat_o});
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, pi, pd, st;
      bit exp_order[$];
      icyc_i = 1; istb_i = 1; dcyc_i = 1; dstb_i = 1; iaddr_i = 32'h44; daddr_i = 32'h88;
      repeat (3) @(negedge clk);
      chk("rst_ctrl", {mcyc_o, mstb_o, mwe_o, iack_o, ierr_o, dack_o, derr_o, timeout_o}, 0);
      chk("rst_bus", {maddr_o, msel_o}, 0);
      chk("rst_mdat", mdat_o, 0);
      chk("rst_rdat", {idat_o, ddat_o}, 0);
      @(posedge clk); #1;
      icyc_i = 0; istb_i = 0; dcyc_i = 0; dstb_i = 0; rst = 0;
      spur = 1;
      repeat (2) begin
         @(negedge clk);
         chk("idle_ack_ignored", {iack_o, ierr_o, dack_o, derr_o, mcyc_o}, 0);
      end
      spur = 0;
      // fetch alone: granted one cycle after the request, ack in cycle 3
      do_txn(0, mk(32'h100, 0, 4'hF, 0, 32'hDEADBEEF, K_ACK, 3), lat);
      chk("fetch_latency", lat, 4);
      idle(0, 1);
      // data write routed onto the slave port
      do_txn(1, mk(32'h2000, 1, 4'b0011, 32'h1234, 0, K_ACK, 2), lat);
      chk("write_latency", lat, 3);
      idle(1, 1);
      // both masters requesting back to back with immediate acks
      order.delete();
      fork
         begin int l; repeat (2) do_txn(0, rnd(0, K_ACK, 1), l); end
         begin int l; repeat (10) do_txn(1, rnd(1, K_ACK, 1), l); end
      join
      idle(0, 0);
      idle(1, 1);
      pi = 2; pd = 10; st = 0;
      while (pi + pd > 0) begin
         if (pd > 0 && !(pi > 0 && st == MDS)) begin exp_order.push_back(1); pd--; st = pi > 0 ? st + 1 : 0; end
         else begin exp_order.push_back(0); pi--; st = 0; end
      end
      chk("order_len", order.size(), exp_order.size());
      foreach (exp_order[i]) if (i < order.size()) chk($sformatf("order_%0d", i), order[i], exp_order[i]);
      // unanswered fetch times out while data waits, then data is served
      fork
         begin int l; do_txn(0, mk(32'h300, 0, 4'hF, 0, 0, K_TO, 1), l); idle(0, 0); end
         begin int l; repeat (3) @(posedge clk); do_txn(1, rnd(1, K_ACK, 2), l); idle(1, 0); end
      join
      // ack or err on the very cycle the timeout would expire
      do_txn(0, mk(32'h400, 0, 4'hF, 0, 32'hCAFE0001, K_ACK, TMO), lat);
      idle(0, 0);
      do_txn(1, mk(32'h8000_0400, 0, 4'h1, 0, 0, K_ERR, TMO), lat);
      idle(1, 1);
      // fetch abandons its cycle mid-grant
      @(posedge clk); #1;
      iaddr_i = 32'h500; iwe_i = 0; icyc_i = 1; istb_i = 1;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!mcyc_o && lat < 10);
      chk("abort_granted", mcyc_o, 1);
      @(posedge clk); #1;
      icyc_i = 0; istb_i = 0;
      @(negedge clk);
      chk("abort_drop", {mcyc_o, iack_o, ierr_o}, 0);
      do_txn(1, mk(32'h8000_0500, 0, 4'hF, 0, 0, K_BOTH, 1), lat);
      chk("after_abort_latency", lat, 2);
      idle(1, 1);
      // asynchronous reset in the middle of a data grant
      @(posedge clk); #1;
      daddr_i = 32'h8000_0600; dwe_i = 1; dcyc_i = 1; dstb_i = 1;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!mcyc_o && lat < 10);
      chk("rst_mid_granted", mcyc_o, 1);
      @(posedge clk); #3;
      rst = 1;
      #1;
      chk("rst_mid_outputs", {mcyc_o, mstb_o, iack_o, ierr_o, dack_o, derr_o, timeout_o}, 0);
      @(posedge clk); #1;
      dcyc_i = 0; dstb_i = 0; rst = 0;
      do_txn(0, mk(32'h700, 0, 4'hF, 0, 32'h600D0700, K_ACK, 1), lat);
      chk("after_rst_latency", lat, 2);
      idle(0, 1);
      // random traffic from both masters
      fork
         begin int l; repeat (40) begin do_txn(0, rnd(0, rnd_kind(), $urandom_range(1, 6)), l); idle(0, $urandom_range(0, 3)); end end
         begin int l; repeat (40) begin do_txn(1, rnd(1, rnd_kind(), $urandom_range(1, 6)), l); idle(1, $urandom_range(0, 3)); end end
      join
      repeat (3) @(negedge clk);
      chk("queues_drained", iq.size() + dq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
